fir_coef_loader: RTL
====================

# fir_coef_loader

Runtime coefficient writer for the parallel transposed FIR filter. Accepts one full coefficient set as a valid/ready stream of `NUM_TAPS` signed words. Buffers the set in a shadow bank, checks the frame length, then commits it atomically to the active bank in a single cycle. The active bank drives the filter's coefficient inputs as a flat bus, so the filter never sees a partially written set.

## Interface
Parameters:
- `NUM_TAPS`, 60, number of coefficients per set; must be ≥ 2.
- `COEF_WIDTH`, 16, signed coefficient width.

Ports:
- `i_clk`, in, 1, single clock.
- `i_rst`, in, 1, synchronous active-high reset.
- `i_coef_valid`, in, 1, stream beat valid.
- `i_coef_data`, in, `COEF_WIDTH`, signed coefficient; beat k is tap k.
- `i_coef_last`, in, 1, marks the final beat of a set.
- `o_coef_ready`, out, 1, loader can accept a beat.
- `o_coefs`, out, `NUM_TAPS*COEF_WIDTH`, active bank; tap k occupies bits [k*COEF_WIDTH +: COEF_WIDTH].
- `o_coef_update`, out, 1, one-cycle pulse in the first cycle new `o_coefs` is visible.
- `o_bank_valid`, out, 1, high once any set has been committed since reset.
- `o_frame_error`, out, 1, one-cycle pulse when a malformed set is discarded.
- `o_commit_count`, out, 8, number of committed sets; wraps 255→0.

## Operation
- A beat transfers on a rising edge where `i_coef_valid` and `o_coef_ready` are both high. Data is stored bit-exact, with no sign manipulation.
- Tap index counter runs 0..`NUM_TAPS`-1. Each accepted beat writes `shadow[index]` and advances the index.
- States:
  - IDLE: index=0, ready=1. An accepted beat writes tap 0 and moves to LOAD, or triggers the error path if `i_coef_last` is set on it.
  - LOAD: ready=1.
    - Beat with `last`=1 at index `NUM_TAPS`-1 → COMMIT.
    - Beat with `last`=1 at index < `NUM_TAPS`-1 → `o_frame_error` pulse, shadow discarded, IDLE.
    - Beat with `last`=0 at index `NUM_TAPS`-1 → DISCARD.
  - COMMIT: exactly one cycle, ready=0. At its closing edge:
    - active ← shadow, all taps simultaneously;
    - `o_coef_update` ← 1;
    - `o_bank_valid` ← 1;
    - `o_commit_count` increments;
    - state → IDLE.
  - DISCARD: ready=1. Beats are dropped until a beat with `last`=1 is accepted. That beat produces an `o_frame_error` pulse and returns to IDLE.
- The active bank changes only at a COMMIT edge. An error or discard leaves `o_coefs`, `o_bank_valid` and `o_commit_count` unchanged.
- `i_coef_valid` low in any state: the state and index hold.

## Timing
- Reset values:
  - `o_coef_ready`=0 during the reset cycle, 1 in the first cycle after reset.
  - `o_coefs`=0, `o_coef_update`=0, `o_bank_valid`=0, `o_frame_error`=0, `o_commit_count`=0.
  - State IDLE, index 0, shadow cleared.
- Commit latency: last beat accepted at edge E → COMMIT during (E, E+1) → new `o_coefs` and `o_coef_update`=1 during (E+1, E+2).
- Throughput: back-to-back sets lose one beat slot, the COMMIT cycle with ready=0.
- `o_frame_error` is registered and high for the single cycle after the offending beat's edge.
- Reset mid-load or mid-commit: shadow discarded, active bank cleared, and no update or error pulse is emitted.
- `o_coef_update` and `o_frame_error` are never high in the same cycle.
- All outputs are registered. No combinational path runs from inputs to outputs, except that `o_coef_ready` is state-decoded only.

## Test plan
- Reset, then stream 60 beats with data = tap index + 1, `last` on beat 59, valid held high: ready low for exactly one cycle after beat 59. Two edges after it, `o_coefs` tap 0 = 0x0001 and tap 59 = 0x003C, `o_coef_update` pulses once, `o_bank_valid`=1, count=1.
- Commit a set of 0x7FFF, then send a 10-beat frame with `last` on beat 9: `o_frame_error` pulses once, `o_coefs` stays all 0x7FFF, count stays 1. Next a valid 60-beat set of 0x8000 commits, giving tap 0 = 0x8000 and count=2.
- Send 65 beats, `last` on beat 64: beats 60–64 are dropped, one error pulse after beat 64, no update. A following good set commits normally.
- Random deassertion of `i_coef_valid` (50%) during a 60-beat set: result is identical to the gapless case, and index holds across gaps.
- Assert `i_rst` at beat 30 of a set: `o_coefs`=0, `o_bank_valid`=0, no pulses. A fresh 60-beat set afterwards commits correctly.
- 256 consecutive good sets: `o_commit_count` wraps to 0, each set produces exactly one update pulse, and update pulses are spaced ≥ 61 cycles apart.

Source files
------------

// File: rtl/fir_coef_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fir_coef_loader
//  Purpose  : Runtime coefficient writer for the transposed FIR filter.
//             Collects one NUM_TAPS-word set from a valid/ready stream into a
//             shadow bank, checks the frame length, then copies the whole set
//             into the active bank in one cycle so the filter never sees a
//             half-written set.
//  Revision : 1.0  initial release
// ============================================================================
module fir_coef_loader #(
    parameter int NUM_TAPS   = 60,
    parameter int COEF_WIDTH = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_coef_valid,
    input  logic [COEF_WIDTH-1:0]          i_coef_data,
    input  logic                           i_coef_last,
    output logic                           o_coef_ready,
    output logic [NUM_TAPS*COEF_WIDTH-1:0] o_coefs,
    output logic                           o_coef_update,
    output logic                           o_bank_valid,
    output logic                           o_frame_error,
    output logic [7:0]                     o_commit_count
);

    localparam int               c_idx_w    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_TAPS - 1);
    localparam logic [c_idx_w-1:0] c_one_idx  = c_idx_w'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMMIT  = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t                        r_state;
    logic [c_idx_w-1:0]            r_idx;
    logic [COEF_WIDTH-1:0]         r_shadow [NUM_TAPS];
    logic                          r_ready;
    logic [NUM_TAPS*COEF_WIDTH-1:0] r_coefs;
    logic                          r_update;
    logic                          r_bank_valid;
    logic                          r_error;
    logic [7:0]                    r_count;

    // A beat moves only when the registered ready (low in COMMIT) meets valid.
    logic w_beat;
    assign w_beat = i_coef_valid & r_ready;

    // Load/commit state machine; every output is a register updated here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_ready      <= 1'b0;
            r_coefs      <= '0;
            r_update     <= 1'b0;
            r_bank_valid <= 1'b0;
            r_error      <= 1'b0;
            r_count      <= 8'd0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_shadow[k] <= '0;
            end
        end else begin
            // Pulses last a single cycle unless re-asserted below.
            r_update <= 1'b0;
            r_error  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    r_idx   <= '0;
                    if (w_beat) begin
                        if (i_coef_last) begin
                            // A one-beat set can never be complete.
                            r_error <= 1'b1;
                        end else begin
                            r_shadow[0] <= i_coef_data;
                            r_idx       <= c_one_idx;
                            r_state     <= S_LOAD;
                        end
                    end
                end

                S_LOAD: begin
                    if (w_beat) begin
                        if (r_idx == c_last_idx) begin
                            r_shadow[r_idx] <= i_coef_data;
                            if (i_coef_last) begin
                                r_state <= S_COMMIT;
                                r_ready <= 1'b0;
                            end else begin
                                // Frame too long: swallow the rest of it.
                                r_state <= S_DISCARD;
                            end
                        end else if (i_coef_last) begin
                            // Frame too short: drop the partial shadow.
                            r_error <= 1'b1;
                            r_idx   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_shadow[r_idx] <= i_coef_data;
                            r_idx           <= r_idx + c_one_idx;
                        end
                    end
                end

                S_COMMIT: begin
                    for (int k = 0; k < NUM_TAPS; k++) begin
                        r_coefs[k*COEF_WIDTH +: COEF_WIDTH] <= r_shadow[k];
                    end
                    r_update     <= 1'b1;
                    r_bank_valid <= 1'b1;
                    r_count      <= r_count + 8'd1;
                    r_idx        <= '0;
                    r_ready      <= 1'b1;
                    r_state      <= S_IDLE;
                end

                S_DISCARD: begin
                    if (w_beat && i_coef_last) begin
                        r_error <= 1'b1;
                        r_idx   <= '0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_idx   <= '0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_coef_ready   = r_ready;
    assign o_coefs        = r_coefs;
    assign o_coef_update  = r_update;
    assign o_bank_valid   = r_bank_valid;
    assign o_frame_error  = r_error;
    assign o_commit_count = r_count;

endmodule
`default_nettype wire
